gamepad_bridge: RTL and testbench

Bridges two Sega-style 6-line gamepads to the CPU's NES-style serial joypad ports ($4016/$4017). It scans each pad by toggling its select line, assembles an 8-button NES vector, and serves that vector bit-serially to the CPU GPIO latch/read strobes. It sits between the board joypad pins and the `core` GPIO interface, in the system clock domain.

---
 rtl/gamepad_pkg.sv | 59 +++++
 rtl/pad_serial.sv | 55 +++++
 rtl/gamepad_bridge.sv | 128 ++++++++++++
 tb/tb_gamepad_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gamepad_pkg
//  Description : Shared definitions for the Sega-pad to NES-joypad bridge.
//                NES button bit positions (bit0 shifts out first), pad line
//                positions for each select phase, the scan FSM state
//                encoding and the pad-to-NES button mapping.
//  Revision    : 1.0  initial release
// ============================================================================
package gamepad_pkg;

    // NES serial order, bit0 is presented first after a load
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Pad lines while select is high
    localparam int HI_UP    = 0;
    localparam int HI_DOWN  = 1;
    localparam int HI_LEFT  = 2;
    localparam int HI_RIGHT = 3;
    localparam int HI_B     = 4;
    localparam int HI_C     = 5;

    // Pad lines while select is low
    localparam int LO_A     = 4;
    localparam int LO_START = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEL_HI = 2'd1,
        ST_SEL_LO = 2'd2
    } scan_state_e;

    // Pad lines are active-low; the NES vector is active-high.
    // The pad's C button acts as NES A and the pad's A button as Select.
    function automatic logic [7:0] map_buttons(input logic [5:0] hi,
                                               input logic       lo_start,
                                               input logic       lo_a);
        logic [7:0] b;
        b             = '0;
        b[BTN_A]      = ~hi[HI_C];
        b[BTN_B]      = ~hi[HI_B];
        b[BTN_SELECT] = ~lo_a;
        b[BTN_START]  = ~lo_start;
        b[BTN_UP]     = ~hi[HI_UP];
        b[BTN_DOWN]   = ~hi[HI_DOWN];
        b[BTN_LEFT]   = ~hi[HI_LEFT];
        b[BTN_RIGHT]  = ~hi[HI_RIGHT];
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_serial.sv
`default_nettype none
// ============================================================================
//  Module      : pad_serial
//  Description : One NES-style serial joypad port. While load_i is high the
//                shift register tracks the button vector; otherwise each
//                rising edge of rden_i shifts right once, filling with 1.
//  Ports       : clk_i, rst_ni     clock / async active-low reset
//                load_i, rden_i    CPU strobe and read indication
//                btn_i[7:0]        current button vector (1 = pressed)
//                data_o            current serial bit
//  Revision    : 1.0  initial release
// ============================================================================
module pad_serial (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       rden_i,
    input  logic [7:0] btn_i,
    output logic       data_o
);

    logic       rden_q;
    logic       shift_q;
    logic       shift_d;
    logic [7:0] shreg_q;
    logic [7:0] shreg_d;

    always_comb begin
        // A read edge that coincides with load is dropped, so it cannot
        // shift the freshly loaded vector one clock later.
        shift_d = rden_i & ~rden_q & ~load_i;
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = btn_i;
        end else if (shift_q) begin
            shreg_d = {1'b1, shreg_q[7:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rden_q  <= 1'b0;
            shift_q <= 1'b0;
            shreg_q <= '0;
        end else begin
            rden_q  <= rden_i;
            shift_q <= shift_d;
            shreg_q <= shreg_d;
        end
    end

    assign data_o = shreg_q[0];

endmodule
`default_nettype wire

// File: rtl/gamepad_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : gamepad_bridge
//  Description : Scans two Sega-style 6-line pads with a shared select FSM
//                and serves each as an NES serial joypad port.
//  Ports       : I_clock, I_reset        clock / async active-low reset
//                I_joy_bits[11:0]        pad lines, [5:0] pad 0, active-low
//                O_joy_mode[1:0]         select line per pad
//                I_GPIO_load[1:0]        CPU strobe per port
//                I_GPIO_rden[1:0]        CPU read indication per port
//                O_GPIO_data[1:0]        serial bit per port, 1 = pressed
//  Revision    : 1.0  initial release
// ============================================================================
module gamepad_bridge
    import gamepad_pkg::*;
#(
    parameter int P_settle = 64,
    parameter int P_period = 21477
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic [11:0] I_joy_bits,
    output logic [1:0]  O_joy_mode,
    input  logic [1:0]  I_GPIO_load,
    input  logic [1:0]  I_GPIO_rden,
    output logic [1:0]  O_GPIO_data
);

    localparam int              CNT_W  = $clog2(P_period);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_period - 1);
    localparam logic [CNT_W-1:0] HI_END   = CNT_W'(P_settle - 1);
    localparam logic [CNT_W-1:0] LO_END   = CNT_W'(2 * P_settle - 1);

    logic [11:0]      sync1_q;
    logic [11:0]      sync2_q;
    logic [11:0]      hi_q;
    logic [1:0][7:0]  btn_q;
    scan_state_e      state_q;
    scan_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic             sample_hi;
    logic             sample_lo;

    // The period counter runs freely; the scan phases are windows of it
    // starting at each wrap, so both pads stay in lockstep.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        sample_hi = 1'b0;
        sample_lo = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q == CNT_LAST) state_d = ST_SEL_HI;
            end
            ST_SEL_HI: begin
                if (cnt_q == HI_END) begin
                    state_d   = ST_SEL_LO;
                    sample_hi = 1'b1;
                end
            end
            ST_SEL_LO: begin
                if (cnt_q == LO_END) begin
                    state_d   = ST_IDLE;
                    sample_lo = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Select is registered from the next state so it moves with the FSM
        mode_d = (state_d == ST_SEL_LO) ? 2'b00 : 2'b11;
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'b11;
        end else begin
            sync1_q <= I_joy_bits;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign O_joy_mode = mode_q;

    for (genvar p = 0; p < 2; p++) begin : g_pad
        // The high-phase sample is parked in hi_q and only merged into the
        // visible vector at the low-phase sample, so a half-scan never shows.
        always_ff @(posedge I_clock or negedge I_reset) begin
            if (!I_reset) begin
                hi_q[p*6 +: 6] <= '1;
                btn_q[p]       <= '0;
            end else begin
                if (sample_hi) begin
                    hi_q[p*6 +: 6] <= sync2_q[p*6 +: 6];
                end
                if (sample_lo) begin
                    btn_q[p] <= map_buttons(hi_q[p*6 +: 6],
                                            sync2_q[p*6 + LO_START],
                                            sync2_q[p*6 + LO_A]);
                end
            end
        end

        pad_serial u_port (
            .clk_i  (I_clock),
            .rst_ni (I_reset),
            .load_i (I_GPIO_load[p]),
            .rden_i (I_GPIO_rden[p]),
            .btn_i  (btn_q[p]),
            .data_o (O_GPIO_data[p])
        );
    end

    // Low-phase lines [3:0] carry no buttons on a 3-button pad
    logic w_unused;
    assign w_unused = ^{sync2_q[3:0], sync2_q[9:6]};

endmodule
`default_nettype wire

// File: tb/tb_gamepad_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gamepad_bridge
//  Description : Self-checking bench for gamepad_bridge. A behavioural pad
//                answers the select line; expected serial bits are queued
//                as loads/reads are driven and compared as they appear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gamepad_bridge;

    localparam int SETTLE = 8;
    localparam int PERIOD = 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [11:0]      joy;
    logic [1:0]       mode;
    logic [1:0]       load = 2'b00;
    logic [1:0]       rden = 2'b00;
    logic [1:0]       data;
    logic [1:0][5:0]  hi_pat = '1;
    logic [1:0][5:0]  lo_pat = '1;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    // Pad model: lines follow the select level the bridge drives
    assign joy = {mode[1] ? hi_pat[1] : lo_pat[1],
                  mode[0] ? hi_pat[0] : lo_pat[0]};

    gamepad_bridge #(
        .P_settle (SETTLE),
        .P_period (PERIOD)
    ) dut (
        .I_clock     (clk),
        .I_reset     (rst_n),
        .I_joy_bits  (joy),
        .O_joy_mode  (mode),
        .I_GPIO_load (load),
        .I_GPIO_rden (rden),
        .O_GPIO_data (data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference mapping: Sega lines (active-low) to NES order (active-high)
    function automatic logic [7:0] nes(input logic [5:0] hi, input logic [5:0] lo);
        return ~{hi[3], hi[2], hi[1], hi[0], lo[5], lo[4], hi[4], hi[5]};
    endfunction

    task automatic wait_scans();
        repeat (2 * PERIOD + 10) @(posedge clk);
    endtask

    task automatic check_out(input int p, input string tag);
        logic e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, {31'd0, data[p]}, {31'd0, e});
        end
    endtask

    task automatic load_port(input int p, input logic [7:0] b);
        @(negedge clk);
        load[p] = 1'b1;
        @(negedge clk);
        load[p] = 1'b0;
        exp_q.push_back(b[0]);
    endtask

    task automatic read_port(input int p, input logic [7:0] b, input int k);
        logic [7:0] bb;
        bb = b;
        @(negedge clk);
        rden[p] = 1'b1;
        @(negedge clk);
        rden[p] = 1'b0;
        @(negedge clk);
        if (k < 8) exp_q.push_back(bb[k[2:0]]);
        else       exp_q.push_back(1'b1);
    endtask

    task automatic run_port(input int p, input logic [7:0] b, input int nreads,
                            input string tag);
        load_port(p, b);
        check_out(p, $sformatf("%s_load", tag));
        for (int k = 1; k <= nreads; k++) begin
            read_port(p, b, k);
            check_out(p, $sformatf("%s_rd%0d", tag, k));
        end
    endtask

    initial begin
        logic [7:0] b;
        int         fall;
        bit         found;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_mode", {30'd0, mode}, 32'h3);
        check_eq("rst_data", {30'd0, data}, 32'h0);
        check_eq("rst_btn", {16'd0, dut.btn_q}, 32'h0);

        // First select fall after release
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        fall  = -1;
        for (int i = 1; i <= 5 * PERIOD && !found; i++) begin
            @(posedge clk);
            #1;
            if (mode[0] == 1'b0) begin
                found = 1'b1;
                fall  = i;
            end
        end
        check_eq("first_fall", fall, PERIOD + SETTLE);

        // Button map: C and Up pressed -> NES A and Up
        hi_pat[0] = 6'b011110;
        lo_pat[0] = 6'b111111;
        wait_scans();
        b = nes(hi_pat[0], lo_pat[0]);
        run_port(0, b, 10, "map");

        // Pad A in the low phase maps to Select
        hi_pat[0] = 6'b111111;
        lo_pat[0] = 6'b101111;
        wait_scans();
        run_port(0, nes(hi_pat[0], lo_pat[0]), 8, "sel");

        // Independence: pad 1 Start only
        hi_pat[0] = '1; lo_pat[0] = '1;
        hi_pat[1] = '1; lo_pat[1] = 6'b011111;
        wait_scans();
        run_port(1, nes(hi_pat[1], lo_pat[1]), 8, "p1");
        run_port(0, nes(hi_pat[0], lo_pat[0]), 8, "p0");
        lo_pat[1] = '1;

        // Held rden gives one shift; load with a coincident edge gives none
        hi_pat[0] = 6'b011110;
        wait_scans();
        b = nes(hi_pat[0], lo_pat[0]);
        load_port(0, b);
        check_out(0, "held_load");
        @(negedge clk);
        rden[0] = 1'b1;
        repeat (20) @(negedge clk);
        exp_q.push_back(b[1]);
        check_out(0, "held_mid");
        rden[0] = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(b[1]);
        check_out(0, "held_end");
        @(negedge clk);
        load[0] = 1'b1;
        rden[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        repeat (4) @(negedge clk);
        rden[0] = 1'b0;
        exp_q.push_back(b[0]);
        check_out(0, "load_rden");

        // Atomic update: lines change after the high-phase sample
        hi_pat[0] = '1;
        lo_pat[0] = '1;
        wait_scans();
        found = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !found; i++) begin
            @(posedge clk);
            #1;
            if (mode[0] == 1'b1) found = 1'b1;
        end
        check_eq("atom_wait_hi", {31'd0, found}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !found; i++) begin
            @(posedge clk);
            #1;
            if (mode[0] == 1'b0) found = 1'b1;
        end
        check_eq("atom_wait_lo", {31'd0, found}, 32'd1);
        hi_pat[0] = 6'b011110;
        lo_pat[0] = 6'b011111;
        for (int j = 1; j <= SETTLE; j++) begin
            @(posedge clk);
            #1;
            if (j == SETTLE - 1)
                check_eq("atom_before", {24'd0, dut.btn_q[0]}, 32'h0);
            if (j == SETTLE)
                check_eq("atom_sample", {24'd0, dut.btn_q[0]},
                         {24'd0, nes(6'b111111, 6'b011111)});
        end
        wait_scans();
        check_eq("atom_next", {24'd0, dut.btn_q[0]},
                 {24'd0, nes(hi_pat[0], lo_pat[0])});

        // Async reset mid-shift, with Start (bit3) showing after 3 reads
        hi_pat[0] = 6'b111111;
        lo_pat[0] = 6'b011111;
        wait_scans();
        run_port(0, nes(hi_pat[0], lo_pat[0]), 3, "ares");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ares_data", {30'd0, data}, 32'h0);
        check_eq("ares_mode", {30'd0, mode}, 32'h3);
        check_eq("ares_btn", {16'd0, dut.btn_q}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
